param_digital_lock: RTL
=======================

Name: param_digital_lock

Overview:
Parametrised successor to the fixed four-button A-B-C-D lock. It supports NUM_KEYS keys, a CODE_LEN-digit code that can be reprogrammed at run time, a lockout after repeated failed attempts, and automatic relock on inactivity. Key inputs arrive already synchronised and debounced, and the block performs its own per-key rising-edge detection. state_out keeps the 3-bit state code so the existing 7-segment decoder can still be driven.

Parameters:
NUM_KEYS, 4, number of key inputs; must be ≥2.
CODE_LEN, 4, number of digits in the code; must be ≥2.
KEY_W, $clog2(NUM_KEYS), localparam; width of one code digit (key index).
DEFAULT_CODE, {2'd3,2'd2,2'd1,2'd0}, CODE_LEN*KEY_W bits loaded at reset; digit i sits at [i*KEY_W +: KEY_W], digit 0 is entered first (default sequence key0,key1,key2,key3).
MAX_FAIL, 3, number of failed attempts that triggers lockout.
LOCKOUT_CYCLES, 1000, length of lockout in clk cycles.
RELOCK_CYCLES, 5000, idle cycles in UNLOCKED before automatic relock.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
keys  in  NUM_KEYS  debounced key levels, one bit per key.
prog_en  in  1  level; requests or holds code-programming mode.
relock  in  1  single-cycle pulse; forces relock from UNLOCKED.
unlocked  out  1  high in UNLOCKED and PROGRAM.
locked_out  out  1  high in LOCKOUT.
progress  out  $clog2(CODE_LEN+1)  number of correct digits entered so far, or digits captured while in PROGRAM.
fail_cnt  out  $clog2(MAX_FAIL+1)  count of failed attempts.
prog_done  out  1  one-cycle pulse when a new code is committed.
state_out  out  3  0=IDLE, 1=ENTRY, 2=UNLOCKED, 3=PROGRAM, 4=LOCKOUT.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; code register=DEFAULT_CODE; keys_q, progress, fail_cnt and timers cleared; all outputs 0. The programmed code is volatile, so a reset mid-operation restores DEFAULT_CODE.
- Edge detect: keys_q <= keys on every clk. press = keys & ~keys_q.
  - Valid press: exactly one bit of press is set; its index k is the digit.
  - Multi-press: two or more bits of press set in the same cycle.
  - A state update happens on the same clk edge that first samples the key high, so outputs are visible one cycle after the key rises.
- IDLE:
  - Valid press with k==code[0] → ENTRY, progress=1.
  - Any other press (wrong key or multi-press) → stay in IDLE. fail_cnt is unchanged.
- ENTRY:
  - Valid press with k==code[progress] → progress+1. If this completes CODE_LEN digits → UNLOCKED, progress=0, fail_cnt=0.
  - Wrong key or multi-press counts as a failed attempt: fail_cnt+1.
    - If fail_cnt reaches MAX_FAIL → LOCKOUT.
    - Otherwise, if the press was valid and k==code[0] → stay in ENTRY with progress=1 (restart on first digit).
    - Otherwise → IDLE, progress=0.
- LOCKOUT:
  - All presses and prog_en are ignored. A counter runs for LOCKOUT_CYCLES cycles.
  - On expiry → IDLE with fail_cnt=0 and progress=0.
- UNLOCKED:
  - relock=1 → IDLE.
  - Otherwise, prog_en=1 → PROGRAM with progress=0.
  - Otherwise, the relock timer counts idle cycles. Any press restarts it. It reaches RELOCK_CYCLES only after that many consecutive cycles with no press, and then → IDLE.
  - If relock and prog_en are both high in the same cycle, relock wins.
- PROGRAM:
  - Each valid press writes k into the shadow register at slot progress, then progress+1. Multi-presses are ignored.
  - After the CODE_LEN-th digit: shadow is copied into the code register, prog_done pulses for one cycle, then → UNLOCKED with progress=0 and the relock timer restarted.
  - prog_en=0 before completion → abort: code unchanged, → UNLOCKED, progress=0.
  - relock pulse → abort and go to IDLE.
  - The relock timer is frozen while in PROGRAM.
- Counters saturate and never wrap: fail_cnt ≤ MAX_FAIL, progress ≤ CODE_LEN.
- Key held high: generates only one press until it is released and pressed again.

Test Plan:
- Default code: reset, then press key0,key1,key2,key3 with release between presses → progress goes 1,2,3, then unlocked=1, state_out=2, fail_cnt=0.
- Restart and fail: key0,key1,key0 → fail_cnt=1, progress=1, state_out=1. Then key2 → fail_cnt=2, state IDLE. Then key0,key3 → fail_cnt=3, locked_out=1, state_out=4.
- Lockout and recovery: press keys during LOCKOUT → no state change. After exactly 1000 cycles → state_out=0, fail_cnt=0. Then the default code unlocks normally.
- Reprogram: unlock, raise prog_en, press key3,key3,key1,key0 → prog_done pulses once, state_out=2. Relock, and the old code no longer unlocks. The new code key3,key3,key1,key0 unlocks. Drop prog_en after 2 digits on a second programming run → code stays key3,key3,key1,key0.
- Auto-relock and simultaneous events: unlock with no presses for 5000 cycles → IDLE. A press at cycle 4999 restarts the count. relock and prog_en high in the same cycle → IDLE.
- Edge cases: keys=4'b0011 rising in one cycle while in ENTRY → counted as a failure. Assert rst low mid-PROGRAM → immediate IDLE and the default code restored.

Source files
------------

// File: rtl/param_digital_lock.sv
// param_digital_lock: reprogrammable NUM_KEYS-key code lock with failed-attempt
// lockout, inactivity auto-relock and a 3-bit state code for the 7-segment decoder.
module param_digital_lock #(
    parameter int NUM_KEYS = 4,
    parameter int CODE_LEN = 4,
    parameter logic [CODE_LEN*$clog2(NUM_KEYS)-1:0] DEFAULT_CODE = {2'd3, 2'd2, 2'd1, 2'd0},
    parameter int MAX_FAIL = 3,
    parameter int LOCKOUT_CYCLES = 1000,
    parameter int RELOCK_CYCLES = 5000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_KEYS-1:0]               keys,
    input  logic                              prog_en,
    input  logic                              relock,
    output logic                              unlocked,
    output logic                              locked_out,
    output logic [$clog2(CODE_LEN+1)-1:0]     progress,
    output logic [$clog2(MAX_FAIL+1)-1:0]     fail_cnt,
    output logic                              prog_done,
    output logic [2:0]                        state_out
);
    localparam int KEY_W = $clog2(NUM_KEYS);
    localparam int PW = $clog2(CODE_LEN + 1);
    localparam int IW = $clog2(CODE_LEN);
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int TMAX = LOCKOUT_CYCLES > RELOCK_CYCLES ? LOCKOUT_CYCLES : RELOCK_CYCLES;
    localparam int TW = $clog2(TMAX + 1);
    localparam logic [TW-1:0] LOCK_LAST = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [TW-1:0] RELOCK_LAST = TW'(RELOCK_CYCLES - 1);
    localparam logic [PW-1:0] LAST_DIGIT = PW'(CODE_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ENTRY    = 3'd1,
        S_UNLOCKED = 3'd2,
        S_PROGRAM  = 3'd3,
        S_LOCKOUT  = 3'd4
    } state_t;

    state_t                           r_state, w_state_nx;
    logic [NUM_KEYS-1:0]              r_keys_q;
    logic [CODE_LEN-1:0][KEY_W-1:0]   r_code, w_code_nx, r_shadow, w_shadow_nx;
    logic [PW-1:0]                    r_progress, w_progress_nx;
    logic [FW-1:0]                    r_fail, w_fail_nx, w_fail_inc;
    logic [TW-1:0]                    r_timer, w_timer_nx;
    logic                             r_prog_done, w_prog_done_nx;
    logic [NUM_KEYS-1:0]              w_press;
    logic [KEY_W-1:0]                 w_k;
    logic [IW-1:0]                    w_idx;
    logic                             w_valid, w_any;

    assign w_press    = keys & ~r_keys_q;
    assign w_valid    = $onehot(w_press);
    assign w_any      = |w_press;
    assign w_idx      = r_progress[IW-1:0];
    assign w_fail_inc = r_fail == FW'(MAX_FAIL) ? r_fail : r_fail + FW'(1);

    always_comb begin
        w_k = '0;
        for (int i = 0; i < NUM_KEYS; i++)
            if (w_press[i]) w_k = KEY_W'(i);
    end

    always_comb begin
        w_state_nx     = r_state;
        w_code_nx      = r_code;
        w_shadow_nx    = r_shadow;
        w_progress_nx  = r_progress;
        w_fail_nx      = r_fail;
        w_timer_nx     = r_timer;
        w_prog_done_nx = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_valid && w_k == r_code[0]) begin
                    w_state_nx    = S_ENTRY;
                    w_progress_nx = PW'(1);
                end
            end
            S_ENTRY: begin
                if (w_valid && w_k == r_code[w_idx]) begin
                    w_progress_nx = r_progress + PW'(1);
                    if (r_progress == LAST_DIGIT) begin
                        w_state_nx    = S_UNLOCKED;
                        w_progress_nx = '0;
                        w_fail_nx     = '0;
                        w_timer_nx    = '0;
                    end
                end else if (w_any) begin
                    w_fail_nx = w_fail_inc;
                    if (w_fail_inc == FW'(MAX_FAIL)) begin
                        w_state_nx    = S_LOCKOUT;
                        w_progress_nx = '0;
                        w_timer_nx    = '0;
                    end else if (w_valid && w_k == r_code[0]) begin
                        w_progress_nx = PW'(1);
                    end else begin
                        w_state_nx    = S_IDLE;
                        w_progress_nx = '0;
                    end
                end
            end
            S_UNLOCKED: begin
                if (relock) begin
                    w_state_nx = S_IDLE;
                end else if (prog_en) begin
                    w_state_nx    = S_PROGRAM;
                    w_progress_nx = '0;
                end else if (w_any) begin
                    w_timer_nx = '0;
                end else if (r_timer == RELOCK_LAST) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_timer_nx = r_timer + TW'(1);
                end
            end
            S_PROGRAM: begin
                // the relock timer is deliberately left untouched here
                if (relock) begin
                    w_state_nx    = S_IDLE;
                    w_progress_nx = '0;
                end else if (!prog_en) begin
                    w_state_nx    = S_UNLOCKED;
                    w_progress_nx = '0;
                end else if (w_valid) begin
                    w_shadow_nx[w_idx] = w_k;
                    w_progress_nx      = r_progress + PW'(1);
                    if (r_progress == LAST_DIGIT) begin
                        w_code_nx      = w_shadow_nx;
                        w_prog_done_nx = 1'b1;
                        w_state_nx     = S_UNLOCKED;
                        w_progress_nx  = '0;
                        w_timer_nx     = '0;
                    end
                end
            end
            S_LOCKOUT: begin
                if (r_timer == LOCK_LAST) begin
                    w_state_nx    = S_IDLE;
                    w_fail_nx     = '0;
                    w_progress_nx = '0;
                end else begin
                    w_timer_nx = r_timer + TW'(1);
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_keys_q    <= '0;
            r_code      <= DEFAULT_CODE;
            r_shadow    <= '0;
            r_progress  <= '0;
            r_fail      <= '0;
            r_timer     <= '0;
            r_prog_done <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_keys_q    <= keys;
            r_code      <= w_code_nx;
            r_shadow    <= w_shadow_nx;
            r_progress  <= w_progress_nx;
            r_fail      <= w_fail_nx;
            r_timer     <= w_timer_nx;
            r_prog_done <= w_prog_done_nx;
        end
    end

    assign unlocked   = r_state == S_UNLOCKED || r_state == S_PROGRAM;
    assign locked_out = r_state == S_LOCKOUT;
    assign progress   = r_progress;
    assign fail_cnt   = r_fail;
    assign prog_done  = r_prog_done;
    assign state_out  = r_state;
endmodule
